mem_beat_sequencer: RTL and testbench

//  Parametrised multi-beat access sequencer for the banked memory / cache datapath.
//  On start it steps through BEATS word/bank indices, one per unstalled cycle, in a selectable order.
//  For reads it also tracks the fixed memory return latency, so the capture side receives matching indices.

---
 rtl/mem_beat_sequencer_pkg.sv | 25 ++
 rtl/mem_beat_sequencer_beat_lat_pipe.sv | 66 ++++++
 rtl/mem_beat_sequencer.sv | 150 +++++++++++++++
 tb/tb_mem_beat_sequencer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mem_beat_sequencer_pkg.sv
// Shared definitions for the multi-beat access sequencer: FSM encodings (also used by
// the cache controller) and parameter legality helpers.
package mem_beat_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    localparam int BEATS_MIN  = 2;
    localparam int BEATS_MAX  = 16;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    function automatic logic beats_legal(input int beats, input int idx_w);
        return (beats >= BEATS_MIN) && (beats <= BEATS_MAX) && (idx_w == $clog2(beats));
    endfunction

    function automatic logic rd_lat_legal(input int rd_lat);
        return (rd_lat >= RD_LAT_MIN) && (rd_lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/mem_beat_sequencer_beat_lat_pipe.sv
// Read-return delay line: RD_LAT stages of {valid,index}, each stage a holdable dff cell.
// The whole line freezes while hold is high so no beat is lost or duplicated.
module beat_dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Storage cell with enable; reset clears to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= {W{1'b0}};
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

module beat_lat_pipe #(
    parameter int RD_LAT = 2,
    parameter int IDX_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              in_valid,
    input  logic [IDX_W-1:0]  in_index,
    output logic              out_valid,
    output logic [IDX_W-1:0]  out_index,
    output logic [RD_LAT-1:0] valid_vec
);

    logic [IDX_W:0] stage_q [RD_LAT];

    for (genvar s = 0; s < RD_LAT; s++) begin : g_stage
        if (s == 0) begin : g_head
            beat_dff #(.W(IDX_W + 1)) u_dff (
                .clk (clk),
                .rst (rst),
                .en  (!hold),
                .d   ({in_valid, in_index}),
                .q   (stage_q[s])
            );
        end else begin : g_body
            beat_dff #(.W(IDX_W + 1)) u_dff (
                .clk (clk),
                .rst (rst),
                .en  (!hold),
                .d   (stage_q[s-1]),
                .q   (stage_q[s])
            );
        end
        assign valid_vec[s] = stage_q[s][IDX_W];
    end

    assign out_valid = stage_q[RD_LAT-1][IDX_W];
    assign out_index = stage_q[RD_LAT-1][IDX_W-1:0];

endmodule

// File: rtl/mem_beat_sequencer.sv
// Multi-beat access sequencer: FSM, beat counter and up/down index mapping, plus the
// read-return delay line that lines capture indices up with returning data.
module mem_beat_sequencer
    import mem_beat_sequencer_pkg::*;
#(
    parameter int BEATS   = 4,
    parameter int IDX_W   = 2,
    parameter int RD_LAT  = 2,
    parameter int DESCEND = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_read,
    input  logic             stall,
    output logic             busy,
    output logic             idx_valid,
    output logic [IDX_W-1:0] index,
    output logic             cap_valid,
    output logic [IDX_W-1:0] cap_index,
    output logic             done,
    output logic             err
);

    localparam logic [IDX_W-1:0]  LAST_CNT   = IDX_W'(BEATS - 1);
    localparam logic [IDX_W-1:0]  FIRST_IDX  = (DESCEND != 0) ? IDX_W'(BEATS - 1) : {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]  IDX_ONE    = IDX_W'(1);
    // Every stage except the last; once these are empty the final capture is on the output.
    localparam logic [RD_LAT-1:0] EARLY_MASK = RD_LAT'((1 << (RD_LAT - 1)) - 1);

    if (!beats_legal(BEATS, IDX_W)) begin : g_bad_beats
        $error("mem_beat_sequencer: BEATS/IDX_W combination is not legal");
    end
    if (!rd_lat_legal(RD_LAT)) begin : g_bad_lat
        $error("mem_beat_sequencer: RD_LAT out of range");
    end

    seq_state_e        state_r;
    seq_state_e        state_s;
    logic              start_acc_s;
    logic [IDX_W-1:0]  cnt_r;
    logic [IDX_W-1:0]  index_r;
    logic              read_r;
    logic              last_beat_s;
    logic              drain_empty_s;
    logic              pipe_valid_s;
    logic [IDX_W-1:0]  pipe_index_s;
    logic [RD_LAT-1:0] pipe_vec_s;
    logic              issue_s;

    assign last_beat_s   = (cnt_r == LAST_CNT);
    assign drain_empty_s = ((pipe_vec_s & EARLY_MASK) == {RD_LAT{1'b0}});
    assign issue_s       = (state_r == ST_ISSUE) && !stall;

    // Next-state logic; stall only freezes the busy states.
    always_comb begin
        state_s     = state_r;
        start_acc_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s     = ST_ISSUE;
                    start_acc_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (issue_s && last_beat_s) begin
                    state_s = read_r ? ST_DRAIN : ST_DONE;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (!stall && drain_empty_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_s     = ST_ISSUE;
                    start_acc_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Beat counter and mapped index; both stop at the terminal beat instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r   <= {IDX_W{1'b0}};
            index_r <= {IDX_W{1'b0}};
            read_r  <= 1'b0;
        end else if (start_acc_s) begin
            cnt_r   <= {IDX_W{1'b0}};
            index_r <= FIRST_IDX;
            read_r  <= is_read;
        end else if (issue_s && !last_beat_s) begin
            cnt_r   <= cnt_r + IDX_ONE;
            index_r <= (DESCEND != 0) ? (index_r - IDX_ONE) : (index_r + IDX_ONE);
        end else begin
            cnt_r   <= cnt_r;
            index_r <= index_r;
            read_r  <= read_r;
        end
    end

    beat_lat_pipe #(
        .RD_LAT (RD_LAT),
        .IDX_W  (IDX_W)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .hold      (stall),
        .in_valid  (issue_s && read_r),
        .in_index  (index_r),
        .out_valid (pipe_valid_s),
        .out_index (pipe_index_s),
        .valid_vec (pipe_vec_s)
    );

    // Output decode; valids are masked by stall, indices simply hold.
    always_comb begin
        busy      = (state_r == ST_ISSUE) || (state_r == ST_DRAIN);
        idx_valid = issue_s;
        index     = index_r;
        cap_valid = pipe_valid_s && !stall;
        cap_index = pipe_index_s;
        done      = (state_r == ST_DONE);
        err       = start && ((state_r == ST_ISSUE) || (state_r == ST_DRAIN));
    end

endmodule

// File: tb/tb_mem_beat_sequencer.sv
// Directed bench for mem_beat_sequencer: per-cycle activity masks and index sequences
// are recorded and compared with hand-computed values.
module tb_mem_beat_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       a_start, a_is_read, a_stall;
    logic       a_busy, a_idx_valid, a_cap_valid, a_done, a_err;
    logic [1:0] a_index, a_cap_index;
    logic       b_start, b_is_read, b_stall;
    logic       b_busy, b_idx_valid, b_cap_valid, b_done, b_err;
    logic [2:0] b_index, b_cap_index;

    mem_beat_sequencer #(.BEATS(4), .IDX_W(2), .RD_LAT(2), .DESCEND(1)) u_dut_a (
        .clk(clk), .rst(rst), .start(a_start), .is_read(a_is_read), .stall(a_stall),
        .busy(a_busy), .idx_valid(a_idx_valid), .index(a_index), .cap_valid(a_cap_valid),
        .cap_index(a_cap_index), .done(a_done), .err(a_err)
    );

    mem_beat_sequencer #(.BEATS(8), .IDX_W(3), .RD_LAT(1), .DESCEND(0)) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .is_read(b_is_read), .stall(b_stall),
        .busy(b_busy), .idx_valid(b_idx_valid), .index(b_index), .cap_valid(b_cap_valid),
        .cap_index(b_cap_index), .done(b_done), .err(b_err)
    );

    int n_total = 0;
    int n_bad   = 0;
    logic [31:0] r_iv, r_cv, r_done, r_busy, r_err, r_iseq, r_cseq;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs ncyc cycles; bit c of each mask drives that input in cycle c (start seen at cycle 0).
    task automatic run_seq(input bit sel, input int ncyc, input logic [31:0] st_m,
                           input logic [31:0] rd_m, input logic [31:0] sl_m);
        logic iv, cv, dn, bz, er;
        logic [3:0] idx, cidx;
        r_iv = '0; r_cv = '0; r_done = '0; r_busy = '0; r_err = '0; r_iseq = '0; r_cseq = '0;
        for (int c = 0; c < ncyc; c++) begin
            if (sel) begin
                b_start = st_m[c]; b_is_read = rd_m[c]; b_stall = sl_m[c];
            end else begin
                a_start = st_m[c]; a_is_read = rd_m[c]; a_stall = sl_m[c];
            end
            #1;
            if (sel) begin
                iv = b_idx_valid; cv = b_cap_valid; dn = b_done; bz = b_busy; er = b_err;
                idx = {1'b0, b_index}; cidx = {1'b0, b_cap_index};
            end else begin
                iv = a_idx_valid; cv = a_cap_valid; dn = a_done; bz = a_busy; er = a_err;
                idx = {2'b00, a_index}; cidx = {2'b00, a_cap_index};
            end
            r_iv   = r_iv   | (32'(iv) << c);
            r_cv   = r_cv   | (32'(cv) << c);
            r_done = r_done | (32'(dn) << c);
            r_busy = r_busy | (32'(bz) << c);
            r_err  = r_err  | (32'(er) << c);
            if (iv) r_iseq = (r_iseq << 4) | 32'(idx);
            if (cv) r_cseq = (r_cseq << 4) | 32'(cidx);
            @(posedge clk);
            #1;
        end
        a_start = 1'b0; a_is_read = 1'b0; a_stall = 1'b0;
        b_start = 1'b0; b_is_read = 1'b0; b_stall = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #1;
        check_val("a_outs_in_rst", 32'({a_busy, a_idx_valid, a_index, a_cap_valid, a_cap_index, a_done, a_err}), 32'h0);
        check_val("b_outs_in_rst", 32'({b_busy, b_idx_valid, b_index, b_cap_valid, b_cap_index, b_done, b_err}), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        a_start = 1'b0; a_is_read = 1'b0; a_stall = 1'b0;
        b_start = 1'b0; b_is_read = 1'b0; b_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("a_reset_state", 32'({a_busy, a_idx_valid, a_index, a_cap_valid, a_cap_index, a_done, a_err}), 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 1: write, descending
        run_seq(1'b0, 8, 32'h1, 32'h0, 32'h0);
        check_val("t1_iv", r_iv, 32'h1E);
        check_val("t1_iseq", r_iseq, 32'h3210);
        check_val("t1_cv", r_cv, 32'h0);
        check_val("t1_done", r_done, 32'h20);
        check_val("t1_busy", r_busy, 32'h1E);

        // 2: read, RD_LAT=2
        run_seq(1'b0, 10, 32'h1, 32'h1, 32'h0);
        check_val("t2_iv", r_iv, 32'h1E);
        check_val("t2_cv", r_cv, 32'h78);
        check_val("t2_cseq", r_cseq, 32'h3210);
        check_val("t2_done", r_done, 32'h80);
        check_val("t2_busy", r_busy, 32'h7E);

        // 3: read with stall in cycles 2-3
        run_seq(1'b0, 12, 32'h1, 32'h1, 32'hC);
        check_val("t3_iv", r_iv, 32'h72);
        check_val("t3_iseq", r_iseq, 32'h3210);
        check_val("t3_cv", r_cv, 32'h1E0);
        check_val("t3_cseq", r_cseq, 32'h3210);
        check_val("t3_done", r_done, 32'h200);
        check_val("t3_busy", r_busy, 32'h1FE);

        // 3b: start together with stall in IDLE, stall also on the first ISSUE cycle
        run_seq(1'b0, 8, 32'h1, 32'h0, 32'h3);
        check_val("t3b_iv", r_iv, 32'h3C);
        check_val("t3b_iseq", r_iseq, 32'h3210);
        check_val("t3b_done", r_done, 32'h40);
        check_val("t3b_busy", r_busy, 32'h3E);

        // 4: second start while busy is dropped with an err pulse
        run_seq(1'b0, 8, 32'h5, 32'h0, 32'h0);
        check_val("t4_err", r_err, 32'h4);
        check_val("t4_iseq", r_iseq, 32'h3210);
        check_val("t4_done", r_done, 32'h20);

        // 5: back-to-back from DONE, second access is a read
        run_seq(1'b0, 14, 32'h21, 32'h20, 32'h0);
        check_val("t5_iv", r_iv, 32'h3DE);
        check_val("t5_iseq", r_iseq, 32'h32103210);
        check_val("t5_cv", r_cv, 32'hF00);
        check_val("t5_cseq", r_cseq, 32'h3210);
        check_val("t5_done", r_done, 32'h1020);
        check_val("t5_busy", r_busy, 32'hFDE);
        check_val("t5_done_and_busy", r_done & r_busy, 32'h0);
        check_val("t5_err", r_err, 32'h0);

        // 6: reset at cycle 3 of a read, then recover
        run_seq(1'b0, 3, 32'h1, 32'h1, 32'h0);
        pulse_reset();
        run_seq(1'b0, 6, 32'h0, 32'h0, 32'h0);
        check_val("t6_no_done", r_done | r_busy, 32'h0);
        run_seq(1'b0, 10, 32'h1, 32'h1, 32'h0);
        check_val("t6_cseq", r_cseq, 32'h3210);
        check_val("t6_done", r_done, 32'h80);

        // 6b: BEATS=8, ascending, RD_LAT=1
        run_seq(1'b1, 3, 32'h1, 32'h1, 32'h0);
        pulse_reset();
        run_seq(1'b1, 6, 32'h0, 32'h0, 32'h0);
        check_val("t6b_no_done", r_done | r_busy, 32'h0);
        run_seq(1'b1, 12, 32'h1, 32'h1, 32'h0);
        check_val("t6b_iv", r_iv, 32'h1FE);
        check_val("t6b_iseq", r_iseq, 32'h01234567);
        check_val("t6b_cv", r_cv, 32'h3FC);
        check_val("t6b_cseq", r_cseq, 32'h01234567);
        check_val("t6b_done", r_done, 32'h400);
        check_val("t6b_busy", r_busy, 32'h3FE);
        run_seq(1'b1, 11, 32'h1, 32'h0, 32'h0);
        check_val("t6b_wr_done", r_done, 32'h200);
        check_val("t6b_wr_cv", r_cv, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
